// File: rtl/mips_mdu.sv
// mips_mdu: multiply/divide unit with HI/LO registers and a fixed-latency busy counter
module mips_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, next;
    logic [7:0] cnt;
    logic [WIDTH-1:0] phi, plo, rhi, rlo, khi, klo, ma, mb, uq, ur;
    logic [2*WIDTH-1:0] prod;
    logic aneg, bneg, bz, commit, issue;

    // result datapath; signed divide goes through magnitudes so most-negative / -1 wraps cleanly
    always_comb begin
        prod = op[0] ? {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}
                     : {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        aneg = ~op[0] & a[WIDTH-1];
        bneg = ~op[0] & b[WIDTH-1];
        bz   = b == '0;
        ma   = aneg ? -a : a;
        mb   = bz ? WIDTH'(1) : bneg ? -b : b;
        uq   = ma / mb;
        ur   = ma % mb;
        khi  = commit ? phi : hi;
        klo  = commit ? plo : lo;
        rhi  = ~op[1] ? prod[2*WIDTH-1:WIDTH] : bz ? khi : aneg ? -ur : ur;
        rlo  = ~op[1] ? prod[WIDTH-1:0] : bz ? klo : (aneg ^ bneg) ? -uq : uq;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : next;
    end

    // next state: a new arithmetic op may be accepted on the commit edge
    always_comb begin
        next = issue ? RUN : commit ? IDLE : state;
    end

    // FSM outputs and handshake decode
    always_comb begin
        busy   = state == RUN;
        commit = busy && cnt == 8'd1;
        issue  = start && !op[2] && (!busy || commit);
    end

    // counter, pending results and architectural HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            phi  <= '0;
            plo  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= commit;
            cnt  <= issue ? (op[1] ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES)) : busy ? cnt - 8'd1 : cnt;
            phi  <= issue ? rhi : phi;
            plo  <= issue ? rlo : plo;
            hi   <= commit ? phi : (!busy && start && op == 3'd4) ? a : hi;
            lo   <= commit ? plo : (!busy && start && op == 3'd5) ? a : lo;
        end
    end
endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: scoreboard bench for the multiply/divide unit
module tb_mips_mdu;
    logic clk = 1'b0, reset, start, start2, busy, done, busy2, done2;
    logic [2:0] op, op2;
    logic [31:0] a, b, hi, lo;
    logic [15:0] a2, b2, hi2, lo2;
    int n_chk = 0, n_fail = 0, run = 0;
    typedef struct { logic [31:0] h, l; } exp_t;
    exp_t exp_q[$], exp2_q[$], e, e2;
    int len_q[$];

    always #5 clk = ~clk;

    mips_mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                  .busy(busy), .done(done), .hi(hi), .lo(lo));
    mips_mdu #(.WIDTH(16), .MULT_CYCLES(1)) dut2 (.clk(clk), .reset(reset), .start(start2), .op(op2),
                  .a(a2), .b(b2), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // commit monitor for the 32-bit unit plus busy run-length check
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else begin
                e = exp_q.pop_front();
                check("commit_hi", hi, e.h);
                check("commit_lo", lo, e.l);
            end
        end
        if (busy === 1'b1) run++;
        else if (run > 0) begin
            if (len_q.size() == 0) check("busy_unexpected", run, 32'd0);
            else check("busy_len", run, len_q.pop_front());
            run = 0;
        end
    end

    // commit monitor for the 16-bit unit
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (exp2_q.size() == 0) check("done2_unexpected", 32'(done2), 32'd0);
            else begin
                e2 = exp2_q.pop_front();
                check("commit2_hi", 32'(hi2), e2.h);
                check("commit2_lo", 32'(lo2), e2.l);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        idle(1);
        start = 1'b0; op = 3'd6;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 40) begin
            idle(1);
            t++;
        end
        if (busy !== 1'b0) check("busy_timeout", 32'(busy), 32'd0);
        idle(1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int len);
        exp_q.push_back('{eh, el});
        len_q.push_back(len);
        issue(o, x, y);
        wait_idle();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd6; a = '0; b = '0;
        start2 = 1'b0; op2 = 3'd6; a2 = '0; b2 = '0;
        idle(2);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        idle(1);
        exp2_q.push_back('{32'h0000FFFE, 32'h00000001});
        start2 = 1'b1; op2 = 3'd1; a2 = 16'hFFFF; b2 = 16'hFFFF;
        idle(1);
        start2 = 1'b0; op2 = 3'd6;
        check("w16_busy_on", 32'(busy2), 32'd1);
        idle(1);
        check("w16_busy_off", 32'(busy2), 32'd0);
        check("w16_hi", 32'(hi2), 32'h0000FFFE);
        check("w16_lo", 32'(lo2), 32'h00000001);
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        issue(3'd4, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        check("mtlo_lo", lo, 32'h5678);
        run_op(3'd2, 32'd5, 32'd0, 32'h1234, 32'h5678, 10);
        issue(3'd4, 32'h0000ABCD, 32'd0);
        check("mthi2_hi", hi, 32'h0000ABCD);
        check("mthi2_lo", lo, 32'h5678);
        check("mthi2_busy", 32'(busy), 32'd0);
        exp_q.push_back('{32'd0, 32'd12});
        len_q.push_back(15);
        issue(3'd0, 32'd3, 32'd4);
        issue(3'd5, 32'd1, 32'd0);
        issue(3'd2, 32'd50, 32'd3);
        check("run_lo_stable", lo, 32'h5678);
        check("run_hi_stable", hi, 32'h0000ABCD);
        check("run_busy", 32'(busy), 32'd1);
        idle(2);
        exp_q.push_back('{32'd2, 32'd14});
        issue(3'd2, 32'd100, 32'd7);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd12);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        len_q.push_back(3);
        issue(3'd2, 32'd9, 32'd2);
        idle(2);
        reset = 1'b0;
        idle(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset = 1'b1;
        idle(15);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("len_q_empty", len_q.size(), 32'd0);
        check("exp2_q_empty", exp2_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mdu.md
# mips_mdu

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core. It executes mult, multu, div, divu, mthi and mtlo issued from the execute stage, models a fixed multi-cycle latency through a busy counter, and exposes HI/LO for mfhi/mflo. The pipeline stalls any MDU-class instruction while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `MULT_CYCLES`, 5: busy duration for mult/multu; legal range 1..255.
- `DIV_CYCLES`, 10: busy duration for div/divu; legal range 1..255.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1  issue strobe, qualified by `op`.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO commit.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. An 8-bit down-counter `cnt` tracks cycles in RUN.
- IDLE, `start`=1, op 0..3:
  - Capture the result into pending registers `phi`/`plo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - HI/LO stay unchanged until commit.
- IDLE, `start`=1, op 4: `hi`<=`a` at that edge. op 5: `lo`<=`a` at that edge. No busy in either case.
- IDLE, `start`=1, op 6/7: no effect.
- RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt` goes 1 to 0: `hi`<=`phi`, `lo`<=`plo`, `done`=1 for the following cycle, return to IDLE.
- `start` in RUN, any op including mthi/mtlo, is ignored. The pipeline guarantees this never happens; the block must still not corrupt state.
- Arithmetic, all modulo WIDTH:
  - MULT: signed 2·WIDTH product; `hi`=upper half, `lo`=lower half.
  - MULTU: unsigned 2·WIDTH product, split the same way.
  - DIV: signed. `lo`=quotient truncated toward zero; `hi`=remainder with the sign of the dividend. Most-negative / −1 gives `lo`=most-negative, `hi`=0.
  - DIVU: unsigned. `lo`=quotient, `hi`=remainder.
  - `b`=0 for DIV/DIVU: full DIV_CYCLES busy, `done` pulses, HI/LO keep their prior values (no commit).
- Reset (`reset`=0 at an edge):
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `cnt`=0, state IDLE, pending results discarded.
  - Applies mid-RUN as well; reset wins over a simultaneous `start`.

## Timing
- `busy` is registered. `start` at edge k (IDLE) gives `busy`=1 after edge k through edge k+N−1, and `busy`=0 after edge k+N. N = MULT_CYCLES or DIV_CYCLES.
- HI/LO new values are visible after edge k+N, coincident with `busy` falling and `done`=1.
- A new `start` is accepted at edge k+N, back-to-back with the commit: `busy` stays 1 and `done` still pulses.
- mthi/mtlo: zero added latency; the new value is visible after the issuing edge.
- `hi`/`lo` are stable during RUN and always hold the last committed or moved value.
- Outputs are registered only; no combinational path from inputs to outputs.

## Test plan
- MULT, a=32'hFFFFFFFF, b=2 -> `busy` for exactly 5 cycles, then hi=FFFFFFFF, lo=FFFFFFFE, one `done` pulse.
- MULTU with the same operands -> hi=00000001, lo=FFFFFFFE after 5 cycles. DIVU 7/2 -> lo=3, hi=1 after 10 cycles.
- DIV a=−7 (FFFFFFF9), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- DIV with b=0 after MTHI 1234 and MTLO 5678 -> 10 busy cycles, `done` pulses, hi=1234 and lo=5678 unchanged. MTHI 0000ABCD from IDLE -> hi=0000ABCD on the next cycle, `busy` never asserted.
- MULT issued, then MTLO 1 and DIV started at cycles 2 and 3 of RUN -> both ignored; MULT result commits on time. A DIV started at the commit edge -> accepted, `busy` continuous for 10 more cycles.
- `reset`=0 at cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, no `done`, no later commit. Repeat with WIDTH=16, MULT_CYCLES=1: 16'hFFFF × 16'hFFFF MULTU -> hi=FFFE, lo=0001 after 1 cycle.
